// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and default widths for the L2 port arbiter.
package l2_arb_pkg;

    localparam int ARB_ADDR_W = 16;
    localparam int ARB_LINE_W = 128;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} arb_state_t;
    typedef enum logic {INST, DATA} owner_t;
    typedef enum logic {CMD_RD, CMD_WR} cmd_t;

    // A requester holding both read and write gets its write served first.
    function automatic cmd_t pick_cmd(input logic rd, input logic wr);
        return (wr || !rd) ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/l2_port_arbiter_if.sv
// L1 icache/dcache request buses and the L2 command bus seen by the arbiter.
interface l2_port_arbiter_if
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
);
    logic              i_mem_read;
    logic              i_mem_write;
    logic [ADDR_W-1:0] i_addr;
    logic [LINE_W-1:0] i_wdata;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;

    logic              d_mem_read;
    logic              d_mem_write;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] d_wdata;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;

    logic              L2_read;
    logic              L2_write;
    logic [ADDR_W-1:0] L2_addr;
    logic [LINE_W-1:0] L2_wdata;
    logic [LINE_W-1:0] L2_rdata;
    logic              L2_resp;

    modport slave (
        input  i_mem_read, i_mem_write, i_addr, i_wdata,
        output i_rdata, i_resp,
        input  d_mem_read, d_mem_write, d_addr, d_wdata,
        output d_rdata, d_resp,
        output L2_read, L2_write, L2_addr, L2_wdata,
        input  L2_rdata, L2_resp
    );

    modport master (
        output i_mem_read, i_mem_write, i_addr, i_wdata,
        input  i_rdata, i_resp,
        output d_mem_read, d_mem_write, d_addr, d_wdata,
        input  d_rdata, d_resp,
        input  L2_read, L2_write, L2_addr, L2_wdata,
        output L2_rdata, L2_resp
    );

endinterface

// File: rtl/l2_port_arbiter_rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one not granted last.
module arb_rr_pick2
    import l2_arb_pkg::*;
(
    input  logic   req_i,
    input  logic   req_d,
    input  owner_t last_grant,
    output logic   grant_valid,
    output owner_t grant_owner
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_owner = INST;
        if (req_i && req_d) begin
            grant_owner = (last_grant == INST) ? DATA : INST;
        end else if (req_d) begin
            grant_owner = DATA;
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Shares one L2 port between icache and dcache; latches the granted command and
// holds it until L2 responds, then pulses the owner's resp for one cycle.
module l2_port_arbiter
    import l2_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int LINE_W = ARB_LINE_W
)(
    input  logic clk,
    input  logic reset_n,
    l2_port_arbiter_if.slave bus
);

    logic              w_req_i;
    logic              w_req_d;
    logic              w_grant_valid;
    owner_t            w_grant_owner;
    cmd_t              w_sel_cmd;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [LINE_W-1:0] w_sel_wdata;

    arb_state_t        r_state;
    owner_t            r_last_grant;
    owner_t            r_owner;
    cmd_t              r_cmd;
    logic [ADDR_W-1:0] r_addr;
    logic [LINE_W-1:0] r_wdata;
    logic              r_l2_read;
    logic              r_l2_write;
    logic              r_i_resp;
    logic              r_d_resp;
    logic [LINE_W-1:0] r_i_rdata_q;
    logic [LINE_W-1:0] r_d_rdata_q;

    assign w_req_i = bus.i_mem_read | bus.i_mem_write;
    assign w_req_d = bus.d_mem_read | bus.d_mem_write;

    arb_rr_pick2 u_pick (
        .req_i       (w_req_i),
        .req_d       (w_req_d),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_owner (w_grant_owner)
    );

    always_comb begin
        if (w_grant_owner == DATA) begin
            w_sel_cmd   = pick_cmd(bus.d_mem_read, bus.d_mem_write);
            w_sel_addr  = bus.d_addr;
            w_sel_wdata = bus.d_wdata;
        end else begin
            w_sel_cmd   = pick_cmd(bus.i_mem_read, bus.i_mem_write);
            w_sel_addr  = bus.i_addr;
            w_sel_wdata = bus.i_wdata;
        end
    end

    // Every output is a register so L2 and both L1s see glitch-free, stable values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last_grant <= INST;
            r_owner      <= INST;
            r_cmd        <= CMD_RD;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_l2_read    <= 1'b0;
            r_l2_write   <= 1'b0;
            r_i_resp     <= 1'b0;
            r_d_resp     <= 1'b0;
            r_i_rdata_q  <= '0;
            r_d_rdata_q  <= '0;
        end else begin
            r_i_resp <= 1'b0;
            r_d_resp <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_owner      <= w_grant_owner;
                        r_last_grant <= w_grant_owner;
                        r_cmd        <= w_sel_cmd;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_l2_read    <= (w_sel_cmd == CMD_RD);
                        r_l2_write   <= (w_sel_cmd == CMD_WR);
                        r_state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.L2_resp) begin
                        r_l2_read  <= 1'b0;
                        r_l2_write <= 1'b0;
                        if (r_owner == INST) begin
                            r_i_resp <= 1'b1;
                            if (r_cmd == CMD_RD) r_i_rdata_q <= bus.L2_rdata;
                        end else begin
                            r_d_resp <= 1'b1;
                            if (r_cmd == CMD_RD) r_d_rdata_q <= bus.L2_rdata;
                        end
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    // Mandatory IDLE afterwards lets the owner drop its request before re-arbitration.
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.L2_read  = r_l2_read;
    assign bus.L2_write = r_l2_write;
    assign bus.L2_addr  = r_addr;
    assign bus.L2_wdata = r_wdata;
    assign bus.i_resp   = r_i_resp;
    assign bus.d_resp   = r_d_resp;
    assign bus.i_rdata  = r_i_rdata_q;
    assign bus.d_rdata  = r_d_rdata_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: hand-computed vectors checked with immediate assertions.
module tb_l2_port_arbiter;
    import l2_arb_pkg::*;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    l2_port_arbiter_if bus ();

    l2_port_arbiter dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called in the first BUSY cycle; returns in the IDLE cycle after the resp pulse.
    task automatic txn(input string tag, input bit own_d, input logic [15:0] addr,
                       input bit is_wr, input logic [127:0] wdata,
                       input logic [127:0] rdata, input int lat);
        for (int c = 0; c < lat; c++) begin
            if (c > 0) tick();
            chk({tag, "_L2_read"},  {127'd0, bus.L2_read},  {127'd0, !is_wr});
            chk({tag, "_L2_write"}, {127'd0, bus.L2_write}, {127'd0, is_wr});
            chk({tag, "_L2_addr"},  {112'd0, bus.L2_addr},  {112'd0, addr});
            if (is_wr) chk({tag, "_L2_wdata"}, bus.L2_wdata, wdata);
        end
        bus.L2_rdata = rdata;
        bus.L2_resp  = 1'b1;
        tick();
        bus.L2_resp  = 1'b0;
        chk({tag, "_resp_d"}, {127'd0, bus.d_resp}, {127'd0, own_d});
        chk({tag, "_resp_i"}, {127'd0, bus.i_resp}, {127'd0, !own_d});
        chk({tag, "_resp_cmd_off"}, {126'd0, bus.L2_read, bus.L2_write}, 128'd0);
        if (!is_wr) chk({tag, "_rdata"}, own_d ? bus.d_rdata : bus.i_rdata, rdata);
        tick();
        chk({tag, "_idle_resp_off"}, {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
        chk({tag, "_idle_cmd_off"}, {126'd0, bus.L2_read, bus.L2_write}, 128'd0);
    endtask

    logic [127:0] w_d3, r_i3, r_i2, r_4a, r_4b, r_4c, r_4d, r_5, w_6, r_6;

    initial begin
        n_checks = 0;
        n_errors = 0;
        w_d3 = {4{32'hD3D3_0003}};
        r_i3 = {4{32'h1313_AAAA}};
        r_i2 = {4{32'hCAFE_0040}};
        r_4a = {4{32'h4A4A_0001}};
        r_4b = {4{32'h4B4B_0002}};
        r_4c = {4{32'h4C4C_0003}};
        r_4d = {4{32'h4D4D_0004}};
        r_5  = {4{32'h5555_3000}};
        w_6  = {4{32'h6666_1230}};
        r_6  = {4{32'h6060_1230}};

        reset_n         = 1'b0;
        bus.i_mem_read  = 1'b0;
        bus.i_mem_write = 1'b0;
        bus.i_addr      = '0;
        bus.i_wdata     = '0;
        bus.d_mem_read  = 1'b0;
        bus.d_mem_write = 1'b0;
        bus.d_addr      = '0;
        bus.d_wdata     = '0;
        bus.L2_rdata    = '0;
        bus.L2_resp     = 1'b0;
        tick();
        tick();
        chk("rst_L2_cmd",  {126'd0, bus.L2_read, bus.L2_write}, 128'd0);
        chk("rst_L2_addr", {112'd0, bus.L2_addr}, 128'd0);
        chk("rst_resp",    {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
        chk("rst_i_rdata", bus.i_rdata, 128'd0);

        // Test 1: async reset during BUSY clears outputs without waiting for an edge.
        reset_n        = 1'b1;
        bus.i_mem_read = 1'b1;
        bus.i_addr     = 16'h0ABC;
        tick();
        chk("t1_busy_read", {127'd0, bus.L2_read}, 128'd1);
        chk("t1_busy_addr", {112'd0, bus.L2_addr}, {112'd0, 16'h0ABC});
        #2;
        reset_n = 1'b0;
        #1;
        chk("t1_async_read", {127'd0, bus.L2_read}, 128'd0);
        chk("t1_async_addr", {112'd0, bus.L2_addr}, 128'd0);
        chk("t1_async_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
        bus.i_mem_read = 1'b0;
        tick();
        tick();

        // Test 3: simultaneous I read and D write straight out of reset: D wins, then I.
        reset_n         = 1'b1;
        bus.i_mem_read  = 1'b1;
        bus.i_addr      = 16'h0100;
        bus.d_mem_write = 1'b1;
        bus.d_addr      = 16'h0200;
        bus.d_wdata     = w_d3;
        tick();
        txn("t3_d_wr", 1'b1, 16'h0200, 1'b1, w_d3, '0, 1);
        bus.d_mem_write = 1'b0;
        tick();
        txn("t3_i_rd", 1'b0, 16'h0100, 1'b0, '0, r_i3, 1);
        bus.i_mem_read = 1'b0;
        chk("t3_d_rdata_hold", bus.d_rdata, 128'd0);
        tick();
        chk("t3_no_regrant", {126'd0, bus.L2_read, bus.L2_write}, 128'd0);

        // Test 2: single I read, L2 answers in the third command cycle.
        bus.i_mem_read = 1'b1;
        bus.i_addr     = 16'h0040;
        tick();
        txn("t2_i_rd", 1'b0, 16'h0040, 1'b0, '0, r_i2, 3);
        bus.i_mem_read = 1'b0;
        bus.L2_resp    = 1'b1;
        tick();
        bus.L2_resp    = 1'b0;
        chk("t2_no_regrant", {126'd0, bus.L2_read, bus.L2_write}, 128'd0);
        tick();
        chk("stray_l2_resp", {126'd0, bus.i_resp, bus.d_resp}, 128'd0);
        chk("t2_i_rdata_hold", bus.i_rdata, r_i2);

        // Test 4: both held continuously; last grant was INST so order is D,I,D,I.
        bus.i_mem_read = 1'b1;
        bus.i_addr     = 16'h1000;
        bus.d_mem_read = 1'b1;
        bus.d_addr     = 16'h2000;
        tick();
        txn("t4_1_d", 1'b1, 16'h2000, 1'b0, '0, r_4a, 1);
        chk("t4_1_i_hold", bus.i_rdata, r_i2);
        tick();
        txn("t4_2_i", 1'b0, 16'h1000, 1'b0, '0, r_4b, 2);
        chk("t4_2_d_hold", bus.d_rdata, r_4a);
        tick();
        txn("t4_3_d", 1'b1, 16'h2000, 1'b0, '0, r_4c, 1);
        tick();
        txn("t4_4_i", 1'b0, 16'h1000, 1'b0, '0, r_4d, 2);
        bus.i_mem_read = 1'b0;
        bus.d_mem_read = 1'b0;
        tick();
        chk("t4_no_regrant", {126'd0, bus.L2_read, bus.L2_write}, 128'd0);

        // Test 5: D read withdrawn mid-BUSY still completes and pulses d_resp once.
        bus.d_mem_read = 1'b1;
        bus.d_addr     = 16'h3000;
        tick();
        chk("t5_read_on", {127'd0, bus.L2_read}, 128'd1);
        bus.d_mem_read = 1'b0;
        tick();
        chk("t5_read_held1", {127'd0, bus.L2_read}, 128'd1);
        chk("t5_addr_held", {112'd0, bus.L2_addr}, {112'd0, 16'h3000});
        tick();
        chk("t5_read_held2", {127'd0, bus.L2_read}, 128'd1);
        bus.L2_rdata = r_5;
        bus.L2_resp  = 1'b1;
        tick();
        bus.L2_resp  = 1'b0;
        chk("t5_d_resp", {127'd0, bus.d_resp}, 128'd1);
        chk("t5_d_rdata", bus.d_rdata, r_5);
        chk("t5_read_off", {127'd0, bus.L2_read}, 128'd0);
        tick();
        chk("t5_d_resp_pulse", {127'd0, bus.d_resp}, 128'd0);
        tick();
        chk("t5_no_regrant", {126'd0, bus.L2_read, bus.L2_write}, 128'd0);

        // Test 6: D read+write together: write first, read as a separate transaction.
        bus.d_mem_read  = 1'b1;
        bus.d_mem_write = 1'b1;
        bus.d_addr      = 16'h1230;
        bus.d_wdata     = w_6;
        tick();
        txn("t6_wr", 1'b1, 16'h1230, 1'b1, w_6, '0, 2);
        bus.d_mem_write = 1'b0;
        tick();
        txn("t6_rd", 1'b1, 16'h1230, 1'b0, '0, r_6, 1);
        bus.d_mem_read = 1'b0;
        tick();
        chk("t6_no_regrant", {126'd0, bus.L2_read, bus.L2_write}, 128'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
